// File: rtl/bitserial_mac_array.sv
// Bit-serial multiply-accumulate engine.
// A job reduces LANES activation/weight pairs into a signed accumulator, one
// activation/weight bit-plane pair per cycle. A single-cycle XNOR-popcount
// mode serves binary layers. The result is held until the consumer takes it.
module bitserial_mac_array #(
    parameter int LANES    = 16,
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*MAX_BITS-1:0]       in_act,
    input  logic [LANES*MAX_BITS-1:0]       in_wgt,
    input  logic [$clog2(MAX_BITS):0]       prec_i,
    input  logic [$clog2(MAX_BITS):0]       prec_w,
    input  logic                            SignI,
    input  logic                            SignW,
    input  logic                            bin,
    input  logic                            acc_clr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_W-1:0]                out_acc
);

    localparam int PREC_W = $clog2(MAX_BITS) + 1;
    localparam int POP_W  = $clog2(LANES + 1);
    localparam int OPS_W  = LANES * MAX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A precision of 0 means 1 bit; anything above MAX_BITS saturates.
    function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p);
        logic [PREC_W-1:0] r;
        if (p == {PREC_W{1'b0}}) begin
            r = PREC_W'(1);
        end else if (p > PREC_W'(MAX_BITS)) begin
            r = PREC_W'(MAX_BITS);
        end else begin
            r = p;
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [OPS_W-1:0]    act_q, act_d;
    logic [OPS_W-1:0]    wgt_q, wgt_d;
    logic [PREC_W-1:0]   pi_q, pi_d;
    logic [PREC_W-1:0]   pw_q, pw_d;
    logic                si_q, si_d;
    logic                sw_q, sw_d;
    logic                bin_q, bin_d;
    logic [PREC_W-1:0]   bi_q, bi_d;
    logic [PREC_W-1:0]   bw_q, bw_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [ACC_W-1:0]    out_acc_q, out_acc_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [POP_W-1:0]    pop_s;
    logic [POP_W-1:0]    popx_s;
    logic [ACC_W-1:0]    mag_s;
    logic [ACC_W-1:0]    term_s;
    logic                bi_last_s;
    logic                bw_last_s;
    logic                neg_s;

    // Current bit-plane term: AND-popcount shifted by plane weight, or XNOR score.
    always_comb begin
        pop_s  = {POP_W{1'b0}};
        popx_s = {POP_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            pop_s  = pop_s + POP_W'(act_q[k*MAX_BITS + int'(bi_q)] & wgt_q[k*MAX_BITS + int'(bw_q)]);
            popx_s = popx_s + POP_W'(~(act_q[k*MAX_BITS] ^ wgt_q[k*MAX_BITS]));
        end
        bi_last_s = (bi_q == (pi_q - PREC_W'(1)));
        bw_last_s = (bw_q == (pw_q - PREC_W'(1)));
        // Sign bits carry negative weight; two negative weights cancel.
        neg_s     = (si_q & bi_last_s) ^ (sw_q & bw_last_s);
        mag_s     = ACC_W'(pop_s) << (bi_q + bw_q);
        if (bin_q) begin
            term_s = (ACC_W'(popx_s) << 1) - ACC_W'(LANES);
        end else if (neg_s) begin
            term_s = {ACC_W{1'b0}} - mag_s;
        end else begin
            term_s = mag_s;
        end
    end

    // Job sequencing: accept, walk bit-plane pairs (bw inner), present result.
    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        wgt_d     = wgt_q;
        pi_d      = pi_q;
        pw_d      = pw_q;
        si_d      = si_q;
        sw_d      = sw_q;
        bin_d     = bin_q;
        bi_d      = bi_q;
        bw_d      = bw_q;
        sum_d     = sum_q;
        out_acc_d = out_acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    act_d   = in_act;
                    wgt_d   = in_wgt;
                    pi_d    = clamp_prec(prec_i);
                    pw_d    = clamp_prec(prec_w);
                    si_d    = SignI;
                    sw_d    = SignW;
                    bin_d   = bin;
                    sum_d   = acc_clr ? {ACC_W{1'b0}} : sum_q;
                    bi_d    = {PREC_W{1'b0}};
                    bw_d    = {PREC_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d = sum_q + term_s;
                if (bin_q || (bi_last_s && bw_last_s)) begin
                    out_acc_d = sum_q + term_s;
                    state_d   = ST_DONE;
                end else if (bw_last_s) begin
                    bw_d = {PREC_W{1'b0}};
                    bi_d = bi_q + PREC_W'(1);
                end else begin
                    bw_d = bw_q + PREC_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            act_q       <= {OPS_W{1'b0}};
            wgt_q       <= {OPS_W{1'b0}};
            pi_q        <= PREC_W'(1);
            pw_q        <= PREC_W'(1);
            si_q        <= 1'b0;
            sw_q        <= 1'b0;
            bin_q       <= 1'b0;
            bi_q        <= {PREC_W{1'b0}};
            bw_q        <= {PREC_W{1'b0}};
            sum_q       <= {ACC_W{1'b0}};
            out_acc_q   <= {ACC_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            wgt_q       <= wgt_d;
            pi_q        <= pi_d;
            pw_q        <= pw_d;
            si_q        <= si_d;
            sw_q        <= sw_d;
            bin_q       <= bin_d;
            bi_q        <= bi_d;
            bw_q        <= bw_d;
            sum_q       <= sum_d;
            out_acc_q   <= out_acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;

endmodule

// File: tb/tb_bitserial_mac_array.sv
// Directed bench for bitserial_mac_array (LANES=4, MAX_BITS=8, ACC_W=32).
// A job-level reference model (dot product of the decoded operand values)
// is compared against the outputs every cycle; directed jobs also pin
// hand-computed results and RUN-cycle counts.
module tb_bitserial_mac_array;

    localparam int LANES = 4;
    localparam int MB    = 8;
    localparam int AW    = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*MB-1:0]   in_act;
    logic [LANES*MB-1:0]   in_wgt;
    logic [3:0]            prec_i;
    logic [3:0]            prec_w;
    logic                  SignI;
    logic                  SignW;
    logic                  bin;
    logic                  acc_clr;
    logic                  out_valid;
    logic                  out_ready;
    logic [AW-1:0]         out_acc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bitserial_mac_array #(.LANES(LANES), .MAX_BITS(MB), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_wgt(in_wgt),
        .prec_i(prec_i), .prec_w(prec_w),
        .SignI(SignI), .SignW(SignW), .bin(bin), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
                     name, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clampf(input logic [3:0] p);
        if (p == 4'd0) return 1;
        if (int'(p) > MB) return MB;
        return int'(p);
    endfunction

    // Decoded value of one lane at precision p, optionally two's complement.
    function automatic longint lane_val(input logic [31:0] v, input int k, input int p, input logic s);
        longint x;
        x = longint'((v >> (k*MB)) & 32'hFF) & ((longint'(1) << p) - 1);
        if (s && x[p-1]) x = x - (longint'(1) << p);
        return x;
    endfunction

    function automatic logic [31:0] job_value(input logic [31:0] a, input logic [31:0] w,
                                              input logic [3:0] pi, input logic [3:0] pw,
                                              input logic si, input logic sw, input logic b);
        longint s;
        s = 0;
        for (int k = 0; k < LANES; k++) begin
            if (b) s = s + ((a[k*MB] == w[k*MB]) ? 1 : -1);
            else   s = s + lane_val(a, k, clampf(pi), si) * lane_val(w, k, clampf(pw), sw);
        end
        return s[31:0];
    endfunction

    function automatic int job_cycles(input logic [3:0] pi, input logic [3:0] pw, input logic b);
        return b ? 1 : clampf(pi) * clampf(pw);
    endfunction

    int          m_phase;   // 0 idle, 1 computing, 2 result held
    int          m_left;
    logic [31:0] m_acc;
    logic [31:0] m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_acc   <= 32'd0;
            m_out   <= 32'd0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_acc   <= (acc_clr ? 32'd0 : m_acc) +
                               job_value(in_act, in_wgt, prec_i, prec_w, SignI, SignW, bin);
                    m_left  <= job_cycles(prec_i, prec_w, bin);
                    m_phase <= 1;
                end
                1: if (m_left == 1) begin
                    m_phase <= 2;
                    m_out   <= m_acc;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0)});
            check("cyc_out_valid", {31'd0, out_valid}, {31'd0, (m_phase == 2)});
            check("cyc_out_acc", out_acc, m_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [3:0] pi,
                         input logic [3:0] pw, input logic si, input logic sw,
                         input logic b, input logic clr);
        in_act = a; in_wgt = w; prec_i = pi; prec_w = pw;
        SignI = si; SignW = sw; bin = b; acc_clr = clr; in_valid = 1'b1;
    endtask

    task automatic scramble();
        in_act  = $urandom;
        in_wgt  = $urandom;
        prec_i  = 4'($urandom_range(0, 15));
        prec_w  = 4'($urandom_range(0, 15));
        SignI   = 1'($urandom_range(0, 1));
        SignW   = 1'($urandom_range(0, 1));
        bin     = 1'($urandom_range(0, 1));
        acc_clr = 1'($urandom_range(0, 1));
    endtask

    // Waits (bounded) for out_valid, counting RUN cycles since acceptance.
    task automatic wait_result(input string name, input logic [31:0] exp_val, input int exp_cyc);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_acc"}, out_acc, exp_val);
        check({name, "_cycles"}, cyc, exp_cyc);
    endtask

    task automatic run_job(input string name, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] pi, input logic [3:0] pw, input logic si,
                           input logic sw, input logic b, input logic clr,
                           input logic [31:0] exp_val, input int exp_cyc);
        drive(a, w, pi, pw, si, sw, b, clr);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_result(name, exp_val, exp_cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_act = '0; in_wgt = '0; prec_i = 4'd0; prec_w = 4'd0;
        SignI = 1'b0; SignW = 1'b0; bin = 1'b0; acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_acc", out_acc, 32'd0);

        run_job("unsigned",   32'h03030303, 32'h03030303, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd36, 4);
        run_job("signed_ss",  32'h00000002, 32'h00000001, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, -32'sd2, 4);
        run_job("signed_su",  32'h00000002, 32'h00000003, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, -32'sd6, 4);
        run_job("signed_nn",  32'h00000003, 32'h00000002, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 4);
        run_job("bin_mixed",  32'h5B07A031, 32'hC20F8103, 4'd7, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1);
        run_job("bin_equal",  32'h11223344, 32'h01020304, 4'd0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 1);
        run_job("bin_differ", 32'h11223344, 32'h10231405, 4'd8, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1, -32'sd4, 1);
        run_job("accum_a",    32'h03030303, 32'h03030303, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd36, 4);
        run_job("accum_b",    32'h03030303, 32'h03030303, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd72, 4);
        run_job("clamp_0_15", 32'h010101FF, 32'h02020281, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 32'd135, 8);
        run_job("clamp_sgn1", 32'h00000001, 32'h00000005, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, -32'sd5, 3);

        // Backpressure: result held while a new request waits.
        drive(32'h03030303, 32'h03030303, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result("bp_first", 32'd36, 4);
        drive(32'h01010101, 32'h01010101, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_acc", out_acc, 32'd36);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", {31'd0, in_ready}, 32'd0);
        wait_result("bp_second", 32'd40, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the second of four RUN cycles.
        drive(32'h03030303, 32'h03030303, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_acc", out_acc, 32'd0);
        run_job("after_rst", 32'h03030303, 32'h03030303, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd36, 4);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
